alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 4-bit combinational ALU macro for the Caravel user area.
- WIDTH-bit operands; 8 operations; status flags.
- Valid/ready handshake on input and output; 2-register pipeline with full backpressure.
- Optional accumulator mode.
- Sits between a Wishbone/LA-driven operand source and a result sink inside the user project.

---
 rtl/alu_pipe_pkg.sv | 20 ++
 rtl/alu_pipe_core.sv | 58 +++++
 rtl/alu_pipe.sv | 139 +++++++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and flag bit positions.
package alu_pipe_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_GTU = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (op, a, b) -> (result, {V,N,Z,C}).
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned     SH_W   = $clog2(WIDTH);
  localparam logic [SH_W-1:0] SH_MAX = SH_W'(WIDTH - 1);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] sh_amt;
  logic            sh_oor;
  logic            carry;
  logic            ovf;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sh_amt = b[SH_W-1:0];
    // Any set bit above the shift field, or a field value past WIDTH-1, clears the result.
    sh_oor = (|(b >> SH_W)) || (sh_amt > SH_MAX);
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_GTU: result = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = sh_oor ? '0 : (a << sh_amt);
      OP_SHR: result = sh_oor ? '0 : (a >> sh_amt);
    endcase
    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_Z] = ~|result;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with full backpressure.
// Optional accumulator mode under ALU_PIPE_ACC_EN; power pins under USE_POWER_PINS.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ALU_PIPE_ACC_EN
  input  logic             in_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [3:0]       s2_flags_q, s2_flags_d;

  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;

`ifdef ALU_PIPE_ACC_EN
  logic             s1_acc_q, s1_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  always_comb begin
    s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_adv;
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid_q & out_ready;
  end

`ifdef ALU_PIPE_ACC_EN
  always_comb op_a = s1_acc_q ? acc_q : s1_a_q;
`else
  always_comb op_a = s1_a_q;
`endif

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op_q),
    .a      (op_a),
    .b      (s1_b_q),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = alu_res;
      s2_flags_d = alu_flags;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

`ifdef ALU_PIPE_ACC_EN
  // Accumulator updates on the same edge the acc beat leaves S1, so the next acc beat sees it.
  always_comb begin
    s1_acc_d = in_fire ? in_acc : s1_acc_q;
    acc_d    = (s2_adv && s1_acc_q) ? alu_res : acc_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_acc_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      s1_acc_q <= s1_acc_d;
      acc_q    <= acc_d;
    end
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    out_data  = s2_data_q;
    out_flags = s2_flags_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8); accumulator vectors run under ALU_PIPE_ACC_EN.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] in_op = '0;
  logic [7:0]      in_a = '0;
  logic [7:0]      in_b = '0;
`ifdef ALU_PIPE_ACC_EN
  logic            in_acc = 1'b0;
`endif
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_data;
  logic [3:0]      out_flags;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic            acc;
    logic [OP_W-1:0] op;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [7:0]      res;
    logic [3:0]      fl;   // {V,N,Z,C}
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef ALU_PIPE_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Streams vecs[0..n-1] back to back with out_ready=1; beat i appears one edge after it is accepted.
  task automatic run_stream(input int n, input string name);
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_op    = vecs[i].op;
        in_a     = vecs[i].a;
        in_b     = vecs[i].b;
`ifdef ALU_PIPE_ACC_EN
        in_acc   = vecs[i].acc;
`endif
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < n) chk($sformatf("%s_in_ready_%0d", name, i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk($sformatf("%s_latency", name), 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("%s_valid_%0d", name, i-1), 32'(out_valid), 32'd1);
        chk($sformatf("%s_data_%0d", name, i-1), 32'(out_data), 32'(vecs[i-1].res));
        chk($sformatf("%s_flags_%0d", name, i-1), 32'(out_flags), 32'(vecs[i-1].fl));
      end
    end
    tick();
    chk($sformatf("%s_drained", name), 32'(out_valid), 32'd0);
  endtask

  task automatic drive(input logic [OP_W-1:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Streaming and op sweep
    vecs[0]  = '{1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[1]  = '{1'b0, OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000};
    vecs[2]  = '{1'b0, OP_AND, 8'hA5, 8'h03, 8'h01, 4'b0000};
    vecs[3]  = '{1'b0, OP_OR,  8'hA5, 8'h03, 8'hA7, 4'b0100};
    vecs[4]  = '{1'b0, OP_XOR, 8'hA5, 8'h03, 8'hA6, 4'b0100};
    vecs[5]  = '{1'b0, OP_GTU, 8'hA5, 8'h03, 8'h01, 4'b0000};
    vecs[6]  = '{1'b0, OP_GTU, 8'h03, 8'hA5, 8'h00, 4'b0010};
    vecs[7]  = '{1'b0, OP_SHL, 8'hA5, 8'h03, 8'h28, 4'b0000};
    vecs[8]  = '{1'b0, OP_SHR, 8'hA5, 8'h03, 8'h14, 4'b0000};
    vecs[9]  = '{1'b0, OP_SHL, 8'hA5, 8'h08, 8'h00, 4'b0010};
    vecs[10] = '{1'b0, OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b0101};
    vecs[11] = '{1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[12] = '{1'b0, OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0000};
    vecs[13] = '{1'b0, OP_SHR, 8'hFF, 8'h10, 8'h00, 4'b0010};
    run_stream(14, "sweep");

    // Backpressure: three beats against a stalled sink
    out_ready = 1'b0;
    drive(OP_ADD, 8'h10, 8'h20);
    #1 chk("bp_in_ready_0", 32'(in_ready), 32'd1);
    tick();
    drive(OP_ADD, 8'h01, 8'h02);
    #1 chk("bp_in_ready_1", 32'(in_ready), 32'd1);
    tick();
    drive(OP_XOR, 8'hFF, 8'h0F);
    #1 chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_valid_stall", 32'(out_valid), 32'd1);
    chk("bp_data_stall0", 32'(out_data), 32'h30);
    repeat (2) begin
      tick();
      chk("bp_in_ready_held", 32'(in_ready), 32'd0);
      chk("bp_data_stable", 32'(out_data), 32'h30);
      chk("bp_flags_stable", 32'(out_flags), 32'h0);
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_order_1_valid", 32'(out_valid), 32'd1);
    chk("bp_order_1_data", 32'(out_data), 32'h03);
    tick();
    chk("bp_order_2_valid", 32'(out_valid), 32'd1);
    chk("bp_order_2_data", 32'(out_data), 32'hF0);
    chk("bp_order_2_flags", 32'(out_flags), 32'b0100);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    drive(OP_ADD, 8'h01, 8'h01);
    tick();
    drive(OP_ADD, 8'h02, 8'h02);
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_flags", 32'(out_flags), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid_no_stale_%0d", k), 32'(out_valid), 32'd0);
    end

`ifdef ALU_PIPE_ACC_EN
    do_reset();
    vecs[0] = '{1'b1, OP_ADD, 8'h99, 8'h05, 8'h05, 4'b0000};
    vecs[1] = '{1'b1, OP_ADD, 8'h99, 8'h07, 8'h0C, 4'b0000};
    vecs[2] = '{1'b0, OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000};
    vecs[3] = '{1'b1, OP_ADD, 8'h00, 8'h00, 8'h0C, 4'b0000};
    run_stream(4, "acc");
    in_acc = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
